// File: rtl/freelist_pkg.sv
// Shared defaults, width helper and PR number type for the physical register free list.
package freelist_pkg;

    localparam int unsigned NUM_PR_DEF  = 64;
    localparam int unsigned NUM_AR_DEF  = 32;
    localparam int unsigned ALLOC_W_DEF = 4;
    localparam int unsigned RET_W_DEF   = 4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    localparam int unsigned PR_W_DEF = clog2(NUM_PR_DEF);

    typedef logic [PR_W_DEF-1:0] pr_t;

endpackage

// File: rtl/prf_freelist_if.sv
// Rename-stage / commit-stage bundle between the renamer and the PR free list.
interface prf_freelist_if
    import freelist_pkg::*;
#(
    parameter int unsigned NUM_PR  = NUM_PR_DEF,
    parameter int unsigned NUM_AR  = NUM_AR_DEF,
    parameter int unsigned ALLOC_W = ALLOC_W_DEF,
    parameter int unsigned RET_W   = RET_W_DEF
);
    localparam int unsigned DEPTH = NUM_PR - NUM_AR;
    localparam int unsigned PR_W  = clog2(NUM_PR);
    localparam int unsigned CNT_W = clog2(DEPTH + 1);
    localparam int unsigned AN_W  = clog2(ALLOC_W + 1);
    localparam int unsigned RN_W  = clog2(RET_W + 1);

    logic                      flush;
    logic                      pause;
    logic [AN_W-1:0]           alloc_num;
    logic                      alloc_ok;
    logic [ALLOC_W*PR_W-1:0]   free_pr;
    logic [AN_W-1:0]           commit_num;
    logic [RN_W-1:0]           release_num;
    logic [RET_W*PR_W-1:0]     release_pr;
    logic [CNT_W-1:0]          room;
    logic                      err;

    modport master (
        output flush, pause, alloc_num, commit_num, release_num, release_pr,
        input  alloc_ok, free_pr, room, err
    );

    modport slave (
        input  flush, pause, alloc_num, commit_num, release_num, release_pr,
        output alloc_ok, free_pr, room, err
    );

endinterface

// File: rtl/freelist_mem.sv
// Free-list storage: circular array with combinational read ports and clocked write ports.
module freelist_mem #(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned PR_W     = 6,
    parameter int unsigned NUM_AR   = 32,
    parameter int unsigned RD_PORTS = 4,
    parameter int unsigned WR_PORTS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RD_PORTS*IDX_W-1:0]  rd_idx_i,
    output logic [RD_PORTS*PR_W-1:0]   rd_data_o,
    input  logic [WR_PORTS-1:0]        wr_en_i,
    input  logic [WR_PORTS*IDX_W-1:0]  wr_idx_i,
    input  logic [WR_PORTS*PR_W-1:0]   wr_data_i
);

    logic [PR_W-1:0] mem_q [DEPTH];

    // Reset seeds entry i with PR NUM_AR+i; otherwise write each enabled release slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PR_W'(NUM_AR + i);
            end
        end else begin
            for (int unsigned j = 0; j < WR_PORTS; j++) begin
                if (wr_en_i[j]) begin
                    mem_q[wr_idx_i[j*IDX_W +: IDX_W]] <= wr_data_i[j*PR_W +: PR_W];
                end
            end
        end
    end

    // Asynchronous read of every allocation slot.
    always_comb begin
        rd_data_o = '0;
        for (int unsigned k = 0; k < RD_PORTS; k++) begin
            rd_data_o[k*PR_W +: PR_W] = mem_q[rd_idx_i[k*IDX_W +: IDX_W]];
        end
    end

endmodule

// File: rtl/prf_freelist.sv
// Physical register free list: speculative/architectural read pointers, release write pointer.
module prf_freelist
    import freelist_pkg::*;
#(
    parameter int unsigned NUM_PR  = NUM_PR_DEF,
    parameter int unsigned NUM_AR  = NUM_AR_DEF,
    parameter int unsigned ALLOC_W = ALLOC_W_DEF,
    parameter int unsigned RET_W   = RET_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    prf_freelist_if.slave  bus
);

    localparam int unsigned DEPTH = NUM_PR - NUM_AR;
    localparam int unsigned PR_W  = clog2(NUM_PR);
    localparam int unsigned CNT_W = clog2(DEPTH + 1);
    localparam int unsigned IDX_W = clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("prf_freelist: NUM_PR-NUM_AR must be a power of two >= 2");
    end
    if (ALLOC_W > DEPTH || RET_W > DEPTH) begin : g_bad_width
        $error("prf_freelist: ALLOC_W and RET_W must not exceed NUM_PR-NUM_AR");
    end

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   wide_t;

    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t a_rd_ptr_q, a_rd_ptr_d;
    ptr_t wr_ptr_q, wr_ptr_d;
    logic err_q, err_d;

    ptr_t  room_w, inflight_w, held_w;
    wide_t used_w;
    logic  alloc_ok_w;

    logic [ALLOC_W*IDX_W-1:0] rd_idx;
    logic [RET_W-1:0]         wr_en;
    logic [RET_W*IDX_W-1:0]   wr_idx;

    // Occupancy, protocol checks and next pointer values.
    always_comb begin
        room_w     = wr_ptr_q - rd_ptr_q;
        inflight_w = rd_ptr_q - a_rd_ptr_q;
        held_w     = wr_ptr_q - a_rd_ptr_q;
        used_w     = {1'b0, held_w} + wide_t'(bus.release_num);
        alloc_ok_w = room_w >= ptr_t'(bus.alloc_num);

        a_rd_ptr_d = a_rd_ptr_q + ptr_t'(bus.commit_num);
        wr_ptr_d   = wr_ptr_q + ptr_t'(bus.release_num);
        rd_ptr_d   = rd_ptr_q;
        // Flush restarts speculation from the architectural pointer including this cycle's commits.
        if (bus.flush) begin
            rd_ptr_d = a_rd_ptr_d;
        end else if (!bus.pause && alloc_ok_w) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(bus.alloc_num);
        end

        err_d = err_q
              | (used_w > wide_t'(DEPTH))
              | (ptr_t'(bus.commit_num) > inflight_w)
              | (bus.alloc_num > $bits(bus.alloc_num)'(ALLOC_W));
    end

    // Storage port addressing: read window at rd_ptr, release slots at wr_ptr.
    always_comb begin
        rd_idx = '0;
        wr_en  = '0;
        wr_idx = '0;
        for (int unsigned k = 0; k < ALLOC_W; k++) begin
            rd_idx[k*IDX_W +: IDX_W] = rd_ptr_q[IDX_W-1:0] + IDX_W'(k);
        end
        for (int unsigned j = 0; j < RET_W; j++) begin
            wr_en[j]                 = j < 32'(bus.release_num);
            wr_idx[j*IDX_W +: IDX_W] = wr_ptr_q[IDX_W-1:0] + IDX_W'(j);
        end
    end

    // Pointer and sticky error registers; reset presents a full list.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            a_rd_ptr_q <= '0;
            wr_ptr_q   <= ptr_t'(DEPTH);
            err_q      <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            a_rd_ptr_q <= a_rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            err_q      <= err_d;
        end
    end

    freelist_mem #(
        .DEPTH    (DEPTH),
        .IDX_W    (IDX_W),
        .PR_W     (PR_W),
        .NUM_AR   (NUM_AR),
        .RD_PORTS (ALLOC_W),
        .WR_PORTS (RET_W)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .rd_idx_i  (rd_idx),
        .rd_data_o (bus.free_pr),
        .wr_en_i   (wr_en),
        .wr_idx_i  (wr_idx),
        .wr_data_i (bus.release_pr)
    );

    assign bus.alloc_ok = alloc_ok_w;
    assign bus.room     = CNT_W'(room_w);
    assign bus.err      = err_q;

endmodule

// File: tb/tb_prf_freelist.sv
// Testbench for prf_freelist: directed vector table plus a randomized rename/commit model.
module tb_prf_freelist;
    import freelist_pkg::*;

    localparam int unsigned DEPTH = NUM_PR_DEF - NUM_AR_DEF;
    localparam int unsigned PW    = $bits(pr_t);
    localparam int          PMASK = 2 * DEPTH - 1;
    localparam int          IMASK = DEPTH - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prf_freelist_if #(
        .NUM_PR(NUM_PR_DEF), .NUM_AR(NUM_AR_DEF), .ALLOC_W(ALLOC_W_DEF), .RET_W(RET_W_DEF)
    ) bus ();

    prf_freelist #(
        .NUM_PR(NUM_PR_DEF), .NUM_AR(NUM_AR_DEF), .ALLOC_W(ALLOC_W_DEF), .RET_W(RET_W_DEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string name;
        int    room;
        int    ok;
        int    s0, s1, s2, s3;   // -1 = not compared
        int    err;
    } exp_t;

    typedef struct {
        bit              do_rst;
        bit              flush;
        bit              pause;
        int              an, cn, rn;
        logic [4*PW-1:0] rp;
        exp_t            e;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state for the randomized phase.
    int   m_mem [DEPTH];
    int   m_rd, m_ard, m_wr;
    bit   inuse [NUM_PR_DEF];
    int   spec_q[$];
    int   arch_q[$];
    int   rel_q[$];

    function automatic exp_t mk_e(string nm, int room, int ok, int s0, int s1, int err);
        exp_t e;
        e.name = nm; e.room = room; e.ok = ok;
        e.s0 = s0; e.s1 = s1; e.s2 = -1; e.s3 = -1; e.err = err;
        return e;
    endfunction

    function automatic vec_t mk_v(bit r, bit fl, bit pz, int an, int cn, int rn,
                                  logic [4*PW-1:0] rp, exp_t e);
        vec_t v;
        v.do_rst = r; v.flush = fl; v.pause = pz;
        v.an = an; v.cn = cn; v.rn = rn; v.rp = rp; v.e = e;
        return v;
    endfunction

    function automatic int slot(int k);
        return int'(bus.free_pr[k*PW +: PW]);
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_front();
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sb.pop_front();
        chk({e.name, ".room"},     int'(bus.room),     e.room);
        chk({e.name, ".alloc_ok"}, int'(bus.alloc_ok), e.ok);
        chk({e.name, ".err"},      int'(bus.err),      e.err);
        if (e.s0 >= 0) chk({e.name, ".slot0"}, slot(0), e.s0);
        if (e.s1 >= 0) chk({e.name, ".slot1"}, slot(1), e.s1);
        if (e.s2 >= 0) chk({e.name, ".slot2"}, slot(2), e.s2);
        if (e.s3 >= 0) chk({e.name, ".slot3"}, slot(3), e.s3);
    endtask

    task automatic drive(bit fl, bit pz, int an, int cn, int rn, logic [4*PW-1:0] rp);
        bus.flush       = fl;
        bus.pause       = pz;
        bus.alloc_num   = 3'(an);
        bus.commit_num  = 3'(cn);
        bus.release_num = 3'(rn);
        bus.release_pr  = rp;
    endtask

    task automatic pulse_reset();
        drive(0, 0, 0, 0, 0, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill/drain, release into an empty list.
        vt.push_back(mk_v(0,0,0,0,0,0,'0, mk_e("reset_state", 32,1,32,33,0)));
        for (int i = 0; i < 8; i++)
            vt.push_back(mk_v(0,0,0,4,0,0,'0,
                mk_e($sformatf("fill%0d", i), 32-4*i, 1, 32+4*i, 33+4*i, 0)));
        vt.push_back(mk_v(0,0,0,1,0,0,'0, mk_e("empty_alloc_a", 0,0,32,33,0)));
        vt.push_back(mk_v(0,0,0,1,0,0,'0, mk_e("empty_alloc_b", 0,0,32,33,0)));
        vt.push_back(mk_v(0,0,0,0,4,0,'0, mk_e("commit_a", 0,1,32,33,0)));
        vt.push_back(mk_v(0,0,0,0,4,0,'0, mk_e("commit_b", 0,1,32,33,0)));
        vt.push_back(mk_v(0,0,0,0,0,2,{6'd0,6'd0,6'd7,6'd5}, mk_e("release_5_7", 0,1,32,33,0)));
        vt.push_back(mk_v(0,0,0,0,0,0,'0, mk_e("after_release", 2,1,5,7,0)));
        // Flush recovery.
        vt.push_back(mk_v(1,0,0,4,0,0,'0, mk_e("fl_alloc0", 32,1,32,33,0)));
        vt.push_back(mk_v(0,0,0,4,0,0,'0, mk_e("fl_alloc1", 28,1,36,37,0)));
        vt.push_back(mk_v(0,0,0,4,0,0,'0, mk_e("fl_alloc2", 24,1,40,41,0)));
        vt.push_back(mk_v(0,0,0,0,5,0,'0, mk_e("fl_commit5", 20,1,44,45,0)));
        vt.push_back(mk_v(0,1,0,0,0,0,'0, mk_e("flush", 20,1,44,45,0)));
        vt.push_back(mk_v(0,0,0,0,0,0,'0, mk_e("after_flush", 27,1,37,38,0)));
        // Flush + pause + commit + release in one cycle.
        vt.push_back(mk_v(0,0,0,4,0,0,'0, mk_e("pre_combo", 27,1,37,38,0)));
        vt.push_back(mk_v(0,1,1,4,2,3,{6'd0,6'd3,6'd2,6'd1}, mk_e("combo", 23,1,41,42,0)));
        vt.push_back(mk_v(0,0,0,0,0,0,'0, mk_e("after_combo", 28,1,39,40,0)));
        // Commit with nothing outstanding: sticky err, pointers keep moving.
        vt.push_back(mk_v(1,0,0,0,1,0,'0, mk_e("bad_commit", 32,1,32,33,0)));
        vt.push_back(mk_v(0,0,0,0,0,0,'0, mk_e("err_set", 32,1,32,33,1)));
        vt.push_back(mk_v(0,0,0,4,0,0,'0, mk_e("err_alloc", 32,1,32,33,1)));
        vt.push_back(mk_v(0,0,0,0,0,0,'0, mk_e("err_held", 28,1,36,37,1)));
        vt.push_back(mk_v(1,0,0,0,0,0,'0, mk_e("err_cleared", 32,1,32,33,0)));
        // alloc_num above ALLOC_W.
        vt.push_back(mk_v(0,0,0,5,0,0,'0, mk_e("alloc5", 32,1,32,33,0)));
        vt.push_back(mk_v(0,0,0,0,0,0,'0, mk_e("alloc5_err", 27,1,37,38,1)));
        // Release into a full list overflows.
        vt.push_back(mk_v(1,0,0,0,0,1,{6'd0,6'd0,6'd0,6'd9}, mk_e("overflow", 32,1,32,33,0)));
        vt.push_back(mk_v(0,0,0,0,0,0,'0, mk_e("overflow_err", 33,1,9,33,1)));

        foreach (vt[i]) begin
            if (vt[i].do_rst) pulse_reset();
            drive(vt[i].flush, vt[i].pause, vt[i].an, vt[i].cn, vt[i].rn, vt[i].rp);
            sb.push_back(vt[i].e);
            @(negedge clk);
            check_front();
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of an allocation.
        drive(0, 0, 4, 0, 0, '0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        sb.push_back(mk_e("async_rst", 32, 1, 32, 33, 0));
        check_front();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized steady-state rename/commit/release against the model.
        pulse_reset();
        m_rd = 0; m_ard = 0; m_wr = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = NUM_AR_DEF + i;
        for (int i = 0; i < NUM_PR_DEF; i++) inuse[i] = (i < NUM_AR_DEF);
        for (int i = 0; i < NUM_AR_DEF; i++) arch_q.push_back(i);

        for (int cyc = 0; cyc < 100; cyc++) begin
            int an, cn, rn, outst, budget, room_e;
            bit pz, acc;
            logic [4*PW-1:0] rp;
            exp_t e;
            an     = int'($urandom_range(0, 4));
            pz     = ($urandom_range(0, 4) == 0);
            outst  = (m_rd - m_ard) & PMASK;
            cn     = int'($urandom_range(0, (outst < 4) ? outst : 4));
            budget = DEPTH - ((m_wr - m_ard) & PMASK);
            rn     = rel_q.size();
            if (rn > 4) rn = 4;
            if (rn > budget) rn = budget;
            rn     = int'($urandom_range(0, rn));
            rp     = '0;
            for (int j = 0; j < rn; j++) rp[j*PW +: PW] = PW'(rel_q[j]);

            room_e = (m_wr - m_rd) & PMASK;
            e = mk_e($sformatf("rand%0d", cyc), room_e, int'(room_e >= an),
                     m_mem[m_rd & IMASK], m_mem[(m_rd + 1) & IMASK], 0);
            e.s2 = m_mem[(m_rd + 2) & IMASK];
            e.s3 = m_mem[(m_rd + 3) & IMASK];
            acc  = (room_e >= an) && !pz;

            drive(0, pz, an, cn, rn, rp);
            sb.push_back(e);
            @(negedge clk);
            check_front();
            if (acc) begin
                for (int k = 0; k < an; k++) begin
                    int v;
                    v = slot(k);
                    chk($sformatf("rand%0d.unique%0d", cyc, k), int'(inuse[v]), 0);
                    inuse[v] = 1'b1;
                    spec_q.push_back(v);
                end
            end
            @(posedge clk);
            #1;

            for (int j = 0; j < rn; j++) begin
                int p;
                p = rel_q.pop_front();
                m_mem[(m_wr + j) & IMASK] = p;
                inuse[p] = 1'b0;
            end
            m_wr = (m_wr + rn) & PMASK;
            if (acc) m_rd = (m_rd + an) & PMASK;
            m_ard = (m_ard + cn) & PMASK;
            for (int c = 0; c < cn; c++) begin
                arch_q.push_back(spec_q.pop_front());
                rel_q.push_back(arch_q.pop_front());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prf_freelist.md
PRF_FREELIST -- requirements
Module: prf_freelist

Interface
REQ-001 SHALL have parameter NUM_PR, default 64: number of physical registers.
REQ-002 SHALL have parameter NUM_AR, default 32: number of architectural registers; DEPTH = NUM_PR-NUM_AR free entries.
REQ-003 SHALL have parameter ALLOC_W, default 4: allocation ports per cycle.
REQ-004 SHALL have parameter RET_W, default 4: release ports per cycle; PR_W = clog2(NUM_PR), CNT_W = clog2(DEPTH+1).
REQ-005 SHALL have port clk, input, 1: the only clock.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port flush, input, 1: squash speculative allocations.
REQ-008 SHALL have port pause, input, 1: rename stage stalled, no allocation.
REQ-009 SHALL have port alloc_num, input, clog2(ALLOC_W+1): PRs requested this cycle.
REQ-010 SHALL have port alloc_ok, output, 1: room >= alloc_num.
REQ-011 SHALL have port free_pr, output, ALLOC_W*PR_W: next ALLOC_W free PRs; slot 0 in the LSBs.
REQ-012 SHALL have port commit_num, input, clog2(ALLOC_W+1): committed instructions that allocated a PR.
REQ-013 SHALL have port release_num, input, clog2(RET_W+1): stale PRs returned at commit.
REQ-014 SHALL have port release_pr, input, RET_W*PR_W: returned PR numbers; slot 0 in the LSBs.
REQ-015 SHALL have port room, output, CNT_W: speculative free count (wr_ptr - rd_ptr).
REQ-016 SHALL have port err, output, 1: sticky protocol-violation flag.

Function
REQ-017 SHALL implement a circular list of DEPTH entries, each PR_W bits wide, with three pointers of clog2(DEPTH)+1 bits: rd_ptr (speculative), a_rd_ptr (architectural) and wr_ptr.
REQ-018 SHALL drive free_pr slot k combinationally from the entry at (rd_ptr+k) mod DEPTH, valid or not.
REQ-019 SHALL advance rd_ptr by alloc_num at the clock edge only when alloc_ok=1, pause=0 and flush=0; otherwise rd_ptr holds.
REQ-020 SHALL write release_pr slots 0..release_num-1 to entries wr_ptr..wr_ptr+release_num-1 and advance wr_ptr by release_num, regardless of pause or flush.
REQ-021 SHALL advance a_rd_ptr by commit_num every cycle, regardless of pause or flush.
REQ-022 SHALL load rd_ptr with a_rd_ptr+commit_num on flush, so commits in the flush cycle are preserved.
REQ-023 SHALL let a release in the same cycle as an allocation take effect in room the next cycle only, with no combinational bypass.
REQ-024 SHALL wrap all pointer arithmetic modulo 2*DEPTH, using the extra MSB to separate full from empty.
REQ-025 SHALL set err for each of three conditions: wr_ptr-a_rd_ptr+release_num > DEPTH (overflow); commit_num exceeding the allocated-uncommitted count rd_ptr-a_rd_ptr; alloc_num > ALLOC_W.
REQ-026 SHALL hold err at 1 until reset once it is set.
REQ-027 SHALL leave pointers and storage updating normally while err=1.

Reset
REQ-028 SHALL, on reset, load entry i with NUM_AR+i, set rd_ptr=a_rd_ptr=0, set wr_ptr=DEPTH (full) and clear err.
REQ-029 SHALL therefore present, out of reset, room=DEPTH, free_pr = NUM_AR..NUM_AR+ALLOC_W-1 and alloc_ok=1 for any alloc_num up to ALLOC_W.
REQ-030 SHALL apply reset immediately when rst asserts mid-operation, discarding in-flight allocations.

Structure
REQ-031 SHALL take NUM_PR/NUM_AR/ALLOC_W/RET_W defaults, a clog2 function and a pr_t typedef from shared package freelist_pkg.
REQ-032 SHALL reject non-power-of-two DEPTH and ALLOC_W > DEPTH at elaboration.
REQ-033 SHALL place storage in one sub-module freelist_mem, with ALLOC_W combinational read ports and RET_W write ports; pointer logic stays in prf_freelist.

Verification
REQ-034 SHALL cover: reset, then alloc_num=4 for 8 cycles -> free_pr 32..63 in order, room 28,24,..,0, then alloc_num=1 -> alloc_ok=0 with rd_ptr held.
REQ-035 SHALL cover: room=0, release_num=2 with PRs 5 and 7 -> next cycle room=2, free_pr slot0=5, slot1=7.
REQ-036 SHALL cover: 3 cycles of alloc 4 (PRs 32..43), commit_num=5, then flush -> room=27, free_pr slot0=37.
REQ-037 SHALL cover: flush with commit_num=2, pause=1 and release_num=3 in the same cycle -> rd_ptr=a_rd_ptr+2, wr_ptr+3, no allocation.
REQ-038 SHALL cover: 100 cycles of random steady alloc/commit/release across pointer wrap -> every PR unique in flight, room consistent with a reference model.
REQ-039 SHALL cover: commit_num=1 with no outstanding allocation -> err=1 and stays 1 until rst pulse.
